alu_serial_ctrl: RTL
====================

Name: alu_serial_ctrl

Overview:
Bit-serial ALU sequencer. Feeds one bitSlice instance LSB-first over WIDTH cycles and holds the inter-bit carry in a flop. Assembles the WIDTH-bit result and status flags, giving a full-width ALU op for the area of a single slice. Sits between the register file/control FSM and the shared slice; uses a start/busy/done handshake.

Parameters:
WIDTH, 64, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; forces IDLE and clears all outputs
start  input  1  request; sampled only in IDLE
op  input  3  slice select: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
A  input  WIDTH  operand A, sampled with start
B  input  WIDTH  operand B, sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  WIDTH  assembled result, held until next accepted start
negative  output  1  result[WIDTH-1]
zero  output  1  result == 0
overflow  output  1  signed overflow, add/sub only, else 0
carry_out  output  1  final slice cout, add/sub only, else 0
err  output  1  one-cycle pulse: start with illegal op (001, 111)

Behaviour:
- States: IDLE, RUN, DONE. Reset value: IDLE; busy, done, err, result, all flags = 0; shift regs, carry, and count = 0.
- IDLE, start=1, legal op (edge 0): latch A and B into shift registers; latch op; carry <= op[0] (1 for sub, 0 otherwise); count <= 0; result <= 0; flags <= 0; go to RUN.
- IDLE, start=1, illegal op: err=1 for the following cycle; stay in IDLE; result and flags unchanged.
- RUN, each edge: slice inputs are Ai = A_sh[0], Bi = B_sh[0], cin = carry, s = op.
  - Shift slice out into result MSB-side; after WIDTH shifts, bit k sits at result[k].
  - carry <= cout. Shift A_sh and B_sh right by 1. count++.
  - When count == WIDTH-1: record carry into MSB (c_msb = current carry) and cout; go to DONE.
- Latency: start accepted on edge 0. RUN occupies edges 1..WIDTH. done is high for the cycle following edge WIDTH. Total WIDTH+1 cycles from start to done.
- busy = 1 exactly in RUN (WIDTH cycles). done = 1 exactly in DONE (1 cycle). DONE -> IDLE unconditionally.
- Flags are registered on entry to DONE and held with result until the next accepted start:
  - negative = result[WIDTH-1]
  - zero = (result == 0)
  - carry_out = final cout for op 010/011, else 0
  - overflow = c_msb XOR final cout for op 010/011, else 0
- Sub uses slice s[0] inversion of B plus carry-in 1, so carry_out = 1 means no borrow.
- start while busy or done is ignored: no queueing, operands not resampled, no err.
- A/B/op changes during RUN have no effect, since latched copies are used.
- reset in any state, including mid-RUN: next cycle IDLE with all outputs 0. The partial result is discarded. start asserted in the same cycle as reset is ignored.
- Back-to-back: start may be asserted in the cycle done is high, but is only sampled in IDLE. Minimum issue interval is WIDTH+2 cycles.

Test Plan:
- WIDTH=8, op=010, A=3, B=5, start one cycle -> busy high 8 cycles; done on cycle 9; result=8; zero=0, negative=0, carry_out=0, overflow=0.
- WIDTH=8, op=011, A=5, B=5 -> result=0; zero=1, carry_out=1, overflow=0. Then A=0x7F, B=0x01 op=010 -> result=0x80; negative=1, overflow=1, carry_out=0.
- WIDTH=8, op=100/101/110/000 with A=0xCC, B=0xAA -> result 0x88 / 0xEE / 0x66 / 0xAA; carry_out=0, overflow=0 in all cases.
- WIDTH=8, add 0xFF+0x01, then during RUN pulse start with op=110, A=0, B=0 -> second start ignored; result=0x00, zero=1, carry_out=1; only one done pulse.
- Start add, assert reset at RUN cycle 4 -> next cycle busy=0, done=0, result=0; no done follows. A new start then completes normally.
- start with op=001, then op=111 -> err pulses one cycle each; busy stays 0, no done, prior result retained.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
// Handshake and data bundle between the requester (register file / control
// FSM) and the bit-serial ALU sequencer.
//
// Handshake: the requester raises start with op/A/B valid for one cycle; the
// request is taken only while the sequencer is idle (busy=0, done=0). busy
// stays high while bits are being processed. done pulses for one cycle when
// result and flags become valid, and they hold until the next accepted start.
// err pulses for one cycle when a start carried an illegal op.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic             err;

  modport master (
    output start, op, A, B,
    input  busy, done, result, negative, zero, overflow, carry_out, err
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, negative, zero, overflow, carry_out, err
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit slice is fed LSB-first for WIDTH cycles,
// the inter-bit carry lives in a flop, and the result is assembled by shifting
// slice outputs in from the MSB side.
module alu_serial_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  alu_serial_ctrl_if.slave   bus,
  output logic [1:0]         state_dbg
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             slice_out;
  logic             slice_cout;
  logic             b_eff;
  logic             arith;
  logic             op_legal;

  // One bit slice; op[0] inverts B for subtract (carry-in is preset to 1).
  always_comb begin
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    b_eff      = b_sh_q[0] ^ op_q[0];
    arith      = (op_q == 3'b010) || (op_q == 3'b011);
    case (op_q)
      3'b000: slice_out = b_sh_q[0];
      3'b010,
      3'b011: begin
        slice_out  = a_sh_q[0] ^ b_eff ^ carry_q;
        slice_cout = (a_sh_q[0] & b_eff) | (carry_q & (a_sh_q[0] ^ b_eff));
      end
      3'b100: slice_out = a_sh_q[0] & b_sh_q[0];
      3'b101: slice_out = a_sh_q[0] | b_sh_q[0];
      3'b110: slice_out = a_sh_q[0] ^ b_sh_q[0];
      default: slice_out = 1'b0;
    endcase
  end

  assign op_legal = (bus.op != 3'b001) && (bus.op != 3'b111);

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    count_d  = count_q;
    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_legal) begin
            a_sh_d   = bus.A;
            b_sh_d   = bus.B;
            op_d     = bus.op;
            carry_d  = bus.op[0];
            count_d  = '0;
            result_d = '0;
            neg_d    = 1'b0;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            cout_d   = 1'b0;
            state_d  = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        result_d = {slice_out, result_q[WIDTH-1:1]};
        carry_d  = slice_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          // carry_q here is the carry into the MSB; compare with carry out.
          neg_d   = result_d[WIDTH-1];
          zero_d  = (result_d == '0);
          cout_d  = arith & slice_cout;
          ovf_d   = arith & (carry_q ^ slice_cout);
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;
  assign bus.err       = err_q;
  assign state_dbg     = state_q;

endmodule
